// File: rtl/systolic_pkg.sv
// Shared constants and command encoding for the systolic FIR chain.
// The chain is fixed at four PEs because that is what the pin map exposes.
package systolic_pkg;

    localparam int DATA_W = 8;
    localparam int N_PE   = 4;
    localparam int ACC_W  = 18;

    typedef enum logic [1:0] {
        CMD_HOLD   = 2'b00,
        CMD_LOAD   = 2'b01,
        CMD_STREAM = 2'b10,
        CMD_CLEAR  = 2'b11
    } cmd_e;

    localparam logic [1:0] SEL_Y_LO   = 2'b00;
    localparam logic [1:0] SEL_Y_MID  = 2'b01;
    localparam logic [1:0] SEL_Y_HI   = 2'b10;
    localparam logic [1:0] SEL_STATUS = 2'b11;

endpackage

// File: rtl/systolic_pe.sv
// One weight-stationary PE: shift-loaded weight, two-deep activation delay, MAC psum.
// Activations advance two regs per PE so that the psum wave lines up with the data.
module systolic_pe
    import systolic_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     stream,
    input  logic                     clear,
    input  logic signed [DATA_W-1:0] w_in,
    output logic signed [DATA_W-1:0] w_out,
    input  logic signed [DATA_W-1:0] act_in,
    output logic signed [DATA_W-1:0] act_out,
    input  logic signed [ACC_W-1:0]  psum_in,
    output logic signed [ACC_W-1:0]  psum_out
);

    logic signed [DATA_W-1:0]   a1;
    logic signed [DATA_W-1:0]   a2;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;

    assign prod     = w_out * act_in;
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign act_out  = a2;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_out    <= '0;
            a1       <= '0;
            a2       <= '0;
            psum_out <= '0;
        end else begin
            if (load)
                w_out <= w_in;
            // Clear keeps the weight so the same filter can be rerun.
            if (clear) begin
                a1       <= '0;
                a2       <= '0;
                psum_out <= '0;
            end else if (stream) begin
                a1       <= act_in;
                a2       <= a1;
                psum_out <= psum_in + prod_ext;
            end
        end
    end

endmodule

// File: rtl/systolic_fir_chain.sv
// Tiny Tapeout wrapper: 4-tap FIR built from a chain of systolic MAC PEs,
// with the 18-bit result and a valid flag read back a byte at a time.
module systolic_fir_chain
    import systolic_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    cmd_e       cmd;
    logic [1:0] sel;
    logic       load;
    logic       stream;
    logic       clear;

    assign cmd    = cmd_e'(uio_in[1:0]);
    assign sel    = uio_in[3:2];
    assign load   = (cmd == CMD_LOAD);
    assign stream = (cmd == CMD_STREAM);
    assign clear  = (cmd == CMD_CLEAR);

    logic [N_PE:0][DATA_W-1:0] wgt;
    logic [N_PE:0][DATA_W-1:0] act;
    logic [N_PE:0][ACC_W-1:0]  psum;

    assign wgt[0]  = ui_in;
    assign act[0]  = ui_in;
    assign psum[0] = '0;

    for (genvar k = 0; k < N_PE; k++) begin : g_pe
        systolic_pe u_pe (
            .clk      (clk),
            .rst      (rst_n),
            .load     (load),
            .stream   (stream),
            .clear    (clear),
            .w_in     (wgt[k]),
            .w_out    (wgt[k+1]),
            .act_in   (act[k]),
            .act_out  (act[k+1]),
            .psum_in  (psum[k]),
            .psum_out (psum[k+1])
        );
    end

    logic [2:0]       beat_cnt;
    logic             valid;
    logic [ACC_W-1:0] y;

    assign y     = psum[N_PE];
    assign valid = (beat_cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (rst_n)
            beat_cnt <= '0;
        else if (clear)
            beat_cnt <= '0;
        else if (stream && !valid)
            beat_cnt <= beat_cnt + 3'd1;
    end

    always_comb begin
        uo_out = '0;
        case (sel)
            SEL_Y_LO:   uo_out = y[7:0];
            SEL_Y_MID:  uo_out = y[15:8];
            SEL_Y_HI:   uo_out = {{6{y[ACC_W-1]}}, y[ACC_W-1:16]};
            SEL_STATUS: uo_out = {7'b0, valid};
            default:    uo_out = '0;
        endcase
    end

    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    // Last PE's forwarded weight/activation have no consumer.
    logic unused_bits;
    assign unused_bits = &{1'b0, ena, uio_in[7:4], wgt[N_PE], act[N_PE]};

endmodule

// File: tb/tb_systolic_fir_chain.sv
// Bench for systolic_fir_chain: FIR-equation model checked every cycle plus literal vectors.
module tb_systolic_fir_chain;
    import systolic_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    systolic_fir_chain dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, got, want, $time);
        end
    endtask

    // Model: y after beat n = sum_k w_k(at beat n-3+k) * x_(n-3-k), weights snapshotted per beat.
    int w[4];
    int xh[1024];
    int wh[1024][4];
    int nb = 0;
    bit model_on = 1'b0;

    function automatic int exp_y();
        int s = 0;
        int n = nb - 1;
        for (int k = 0; k < 4; k++) begin
            int xi = n - 3 - k;
            if (xi >= 0) s += wh[n - 3 + k][k] * xh[xi];
        end
        return s;
    endfunction

    function automatic logic [7:0] exp_byte(input logic [1:0] s);
        logic [17:0] yv = 18'(exp_y());
        case (s)
            2'b00:   return yv[7:0];
            2'b01:   return yv[15:8];
            2'b10:   return {{6{yv[17]}}, yv[17:16]};
            default: return {7'b0, nb >= 7};
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst_n) begin
            for (int k = 0; k < 4; k++) w[k] = 0;
            nb = 0;
            model_on = 1'b1;
        end else begin
            case (uio_in[1:0])
                2'b01: begin
                    w[3] = w[2]; w[2] = w[1]; w[1] = w[0];
                    w[0] = int'($signed(ui_in));
                end
                2'b10: begin
                    xh[nb] = int'($signed(ui_in));
                    for (int k = 0; k < 4; k++) wh[nb][k] = w[k];
                    nb++;
                end
                2'b11: nb = 0;
                default: ;
            endcase
        end
    end

    initial forever begin
        @(negedge clk);
        if (model_on) begin
            check("model_uo_out", uo_out, exp_byte(uio_in[3:2]));
            check("uio_out", uio_out, 8'h00);
            check("uio_oe", uio_oe, 8'h00);
        end
    end

    task automatic step(input cmd_e c, input logic [7:0] d);
        ui_in  = d;
        uio_in = {4'b0, 2'b00, c};
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input logic [1:0] s, input logic [7:0] want, input string name);
        uio_in = {4'b0, s, CMD_HOLD};
        #1;
        check(name, uo_out, want);
    endtask

    task automatic read_all(input logic [7:0] b0, b1, b2, b3, input string name);
        chk(2'b00, b0, {name, "_sel0"});
        chk(2'b01, b1, {name, "_sel1"});
        chk(2'b10, b2, {name, "_sel2"});
        chk(2'b11, b3, {name, "_sel3"});
    endtask

    task automatic load4(input logic [7:0] a, b, c, d);
        step(CMD_LOAD, a); step(CMD_LOAD, b); step(CMD_LOAD, c); step(CMD_LOAD, d);
    endtask

    logic [7:0] imp[8] = '{8'd0, 8'd0, 8'd0, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    logic [7:0] vld[8] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1};

    initial begin
        ena = 1'b1; rst_n = 1'b1; ui_in = '0; uio_in = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        read_all(8'h00, 8'h00, 8'h00, 8'h00, "reset");
        check("reset_uio_oe", uio_oe, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);

        // Impulse response with a HOLD gap after beat 4.
        load4(8'd1, 8'd2, 8'd3, 8'd4);
        step(CMD_CLEAR, 8'h00);
        for (int n = 0; n < 8; n++) begin
            step(CMD_STREAM, (n == 0) ? 8'd1 : 8'd0);
            chk(SEL_Y_LO, imp[n], "impulse_y");
            chk(SEL_STATUS, vld[n], "impulse_valid");
            if (n == 4) begin
                repeat (5) step(CMD_HOLD, 8'h55);
                chk(SEL_Y_LO, 8'd3, "hold_y");
                chk(SEL_STATUS, 8'd0, "hold_valid");
            end
        end

        // CLEAR mid-stream, then rerun the impulse with the kept weights.
        step(CMD_STREAM, 8'd5); step(CMD_STREAM, 8'hFD); step(CMD_STREAM, 8'd9);
        step(CMD_STREAM, 8'd7); step(CMD_STREAM, 8'd2);
        step(CMD_CLEAR, 8'h00);
        read_all(8'h00, 8'h00, 8'h00, 8'h00, "clear");
        for (int n = 0; n < 7; n++) begin
            step(CMD_STREAM, (n == 0) ? 8'd1 : 8'd0);
            chk(SEL_Y_LO, imp[n], "reimpulse_y");
        end

        // Extreme magnitudes.
        load4(8'h80, 8'h80, 8'h80, 8'h80);
        step(CMD_CLEAR, 8'h00);
        repeat (7) step(CMD_STREAM, 8'h80);
        read_all(8'h00, 8'h00, 8'h01, 8'h01, "maxpos");
        step(CMD_CLEAR, 8'h00);
        repeat (7) step(CMD_STREAM, 8'h7F);
        read_all(8'h00, 8'h02, 8'hFF, 8'h01, "maxneg");

        // Mixed-sign data with a weight reload mid-stream (model-checked).
        load4(8'd3, 8'hFB, 8'd7, 8'hFE);
        step(CMD_CLEAR, 8'h00);
        step(CMD_STREAM, 8'd10); step(CMD_STREAM, 8'hEC); step(CMD_STREAM, 8'd30);
        step(CMD_LOAD, 8'd6);
        step(CMD_STREAM, 8'h81); step(CMD_STREAM, 8'd127); step(CMD_STREAM, 8'hF0);
        for (int s = 0; s < 4; s++) begin
            step(CMD_STREAM, 8'(s * 37 - 50));
            chk(2'(s), exp_byte(2'(s)), "mixed_model");
        end

        // Reset mid-stream wipes the weights.
        rst_n = 1'b1;
        step(CMD_STREAM, 8'd44);
        rst_n = 1'b0;
        read_all(8'h00, 8'h00, 8'h00, 8'h00, "midrst");
        for (int n = 0; n < 9; n++) step(CMD_STREAM, 8'(n * 29 + 3));
        read_all(8'h00, 8'h00, 8'h00, 8'h01, "postrst");

        step(CMD_HOLD, 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_fir_chain.md
Name: systolic_fir_chain

Overview:
- Tiny Tapeout user-project top wrapping a 4-PE, weight-stationary 1-D systolic chain of signed 8x8 multiply-accumulate processing elements.
- Weights are shifted in serially, activations are streamed one per beat, and the chain produces a 4-tap FIR result.
- The result is read back one byte at a time on uo_out.
- The block sits directly under the chip-level harness; all control arrives on uio_in.

Parameters:
- N_PE, 4, number of processing elements in the chain (fixed at 4 for the pin map).
- ACC_W, 18, accumulator/result width (16 + clog2(N_PE)), two's complement.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  reset; synchronous, active-high (1 = reset).
- ena  in  1  design-selected indicator; ignored by logic.
- ui_in  in  8  signed data byte: a weight on LOAD, an activation on STREAM.
- uio_in  in  8  control: [1:0] cmd, [3:2] read select, [7:4] unused.
- uo_out  out  8  selected result/status byte.
- uio_out  out  8  tied 8'h00.
- uio_oe  out  8  tied 8'h00 (all uio pins are inputs).

Behaviour:
- cmd encoding:
  - 00 HOLD: no state change.
  - 01 LOAD: w3<=w2, w2<=w1, w1<=w0, w0<=ui_in.
  - 10 STREAM: advance the chain one beat.
  - 11 CLEAR: zero the activation regs, psums and beat counter; weights are kept.
- Reset (rst_n=1 at a clk edge) has priority over any cmd. It zeroes all weights, activation regs, psums and the beat counter. uo_out=0 after reset.
- PE k state: weight w_k (8b signed), two activation regs a_k1 and a_k2 (8b), psum p_k (ACC_W).
- On a STREAM beat:
  - Activation inputs: in_0 = ui_in; in_k = a_(k-1)2 for k ≥ 1.
  - Activation shift: a_k1<=in_k, a_k2<=a_k1.
  - Psum update: p_k <= p_(k-1) + sext(w_k*in_k), with p_(-1)=0.
  - All arithmetic is signed, full precision, and cannot overflow in ACC_W.
- Result y = p_3. After STREAM beat n (first beat after reset/clear is n=0), y = sum over k=0..3 of w_k*x_(n-3-k), where x_j=0 for j<0. This is a 3-beat latency FIR.
- The chain advances only on STREAM beats; HOLD or LOAD between beats freezes the activation regs and psums.
- LOAD during streaming changes the weights immediately; only psums computed after the change use the new weights.
- Beat counter: 3 bits, increments on STREAM, saturates at 7. valid = (count == 7).
- uo_out (combinational mux of registered state) by select [3:2]:
  - 00: y[7:0]
  - 01: y[15:8]
  - 10: 6-bit sign extension of y[17], then y[17:16]
  - 11: {7'b0, valid}

Decomposition:
- Package systolic_pkg: cmd enum (CMD_HOLD, CMD_LOAD, CMD_STREAM, CMD_CLEAR), read-select constants, DATA_W=8, N_PE=4, ACC_W=18.
- Sub-module systolic_pe contains: weight reg with a load-shift port, 2-deep activation delay, MAC psum reg, and an enable/clear input.
- The top instantiates 4 PEs via generate, and also holds the beat counter and the output mux.

Test Plan:
- Reset, then read all 4 selects -> 0x00 each; uio_oe=0x00, uio_out=0x00.
- LOAD 1,2,3,4 (giving w3=1, w0=4), CLEAR, STREAM 1 then zeros -> y read after beats 3,4,5,6,7 = 4,3,2,1,0; valid=1 from beat 6 on.
- All weights 0x80, STREAM 0x80 x7 -> y=0x10000: sel00=0x00, sel01=0x00, sel10=0x01.
- All weights 0x80, STREAM 0x7F x7 -> y=-65024: sel00=0x00, sel01=0x02, sel10=0xFF.
- HOLD x5 mid-stream -> y and valid unchanged. CLEAR mid-stream -> y=0, valid=0, and reused weights give the impulse response 4,3,2,1 again.
- rst_n pulsed mid-stream -> weights zero, so any streamed data yields y=0.
